// File: rtl/cpu_store_buffer.sv
// In-order store buffer between the MEM stage and data memory.
// Supports youngest-match load forwarding and optional coalescing of repeat stores.
module cpu_store_buffer #(
    parameter int DW       = 16,
    parameter int AW       = 8,
    parameter int DEPTH    = 4,
    parameter int COALESCE = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    flush,
    input  logic                    st_valid,
    input  logic [AW-1:0]           st_addr,
    input  logic [DW-1:0]           st_data,
    output logic                    st_ready,
    input  logic [AW-1:0]           ld_addr,
    output logic                    ld_hit,
    output logic [DW-1:0]           ld_data,
    output logic [AW-1:0]           d_addr,
    output logic [DW-1:0]           d_dataout,
    output logic                    d_we,
    input  logic                    d_ready,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    logic          pop, push, co_hit, co_wr, alloc;
    logic [PW-1:0] co_idx, idx;

    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign st_ready  = !flush && (count_q < CW'(DEPTH));
    assign d_we      = enable && !empty;
    assign d_addr    = addr_q[head_q];
    assign d_dataout = data_q[head_q];
    assign pop       = d_we && d_ready;
    assign push      = st_valid && st_ready;

    // Walk oldest to youngest from head so the last match seen is the youngest.
    always_comb begin
        co_hit  = 1'b0;
        co_idx  = '0;
        ld_hit  = 1'b0;
        ld_data = '0;
        idx     = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (valid_q[idx] && addr_q[idx] == st_addr) begin
                co_hit = 1'b1;
                co_idx = idx;
            end
            if (valid_q[idx] && addr_q[idx] == ld_addr) begin
                ld_hit  = 1'b1;
                ld_data = data_q[idx];
            end
        end
    end

    // The head being popped this cycle cannot absorb a new store; allocate instead.
    always_comb begin
        co_wr   = (COALESCE != 0) && push && co_hit && !(pop && co_idx == head_q);
        alloc   = push && !co_wr;
        head_d  = pop   ? head_q + PW'(1) : head_q;
        tail_d  = alloc ? tail_q + PW'(1) : tail_q;
        count_d = count_q + CW'(alloc) - CW'(pop);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (pop) valid_q[head_q] <= 1'b0;
            if (alloc) begin
                valid_q[tail_q] <= 1'b1;
                addr_q[tail_q]  <= st_addr;
                data_q[tail_q]  <= st_data;
            end
            if (co_wr) data_q[co_idx] <= st_data;
        end
    end
endmodule

// File: tb/tb_cpu_store_buffer.sv
// Bench for cpu_store_buffer: coalescing and non-coalescing instances share stimulus
// and are compared every cycle against ordered-list models of the buffer contents.
module tb_cpu_store_buffer;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam int DEPTH = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b1, flush = 1'b0, st_valid = 1'b0, d_ready = 1'b1;
    logic [AW-1:0] st_addr = '0, ld_addr = '0;
    logic [DW-1:0] st_data = '0;

    logic [1:0]    rdy_w, hit_w, we_w, empty_w;
    logic [DW-1:0] ldd_w  [2];
    logic [AW-1:0] da_w   [2];
    logic [DW-1:0] dd_w   [2];
    logic [2:0]    cnt_w  [2];

    int total = 0, passed = 0;

    always #5 clock = ~clock;

    cpu_store_buffer #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .COALESCE(1)) u_c1 (
        .clock(clock), .reset(reset), .enable(enable), .flush(flush),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(rdy_w[1]),
        .ld_addr(ld_addr), .ld_hit(hit_w[1]), .ld_data(ldd_w[1]),
        .d_addr(da_w[1]), .d_dataout(dd_w[1]), .d_we(we_w[1]), .d_ready(d_ready),
        .count(cnt_w[1]), .empty(empty_w[1]));

    cpu_store_buffer #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .COALESCE(0)) u_c0 (
        .clock(clock), .reset(reset), .enable(enable), .flush(flush),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(rdy_w[0]),
        .ld_addr(ld_addr), .ld_hit(hit_w[0]), .ld_data(ldd_w[0]),
        .d_addr(da_w[0]), .d_dataout(dd_w[0]), .d_we(we_w[0]), .d_ready(d_ready),
        .count(cnt_w[0]), .empty(empty_w[0]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    endtask

    // Model: index 0 is the oldest pending store; list k=1 coalesces, k=0 does not.
    logic [AW-1:0] m_a [2][DEPTH];
    logic [DW-1:0] m_d [2][DEPTH];
    int            m_n [2] = '{0, 0};
    logic          m_pop, m_push;
    int            m_hit;
    logic [DW:0]   cmp_ld;

    function automatic logic e_ready(int k);
        return !flush && (m_n[k] < DEPTH);
    endfunction

    function automatic logic e_we(int k);
        return enable && (m_n[k] > 0);
    endfunction

    function automatic logic [DW:0] e_ld(int k);
        logic [DW:0] r;
        r = '0;
        for (int j = 0; j < m_n[k]; j++)
            if (m_a[k][j] == ld_addr) r = {1'b1, m_d[k][j]};
        return r;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_n[0] = 0;
            m_n[1] = 0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_pop  = e_we(k) && d_ready;
                m_push = st_valid && e_ready(k);
                m_hit  = -1;
                if (m_push) begin
                    if (k == 1)
                        for (int j = 0; j < m_n[k]; j++)
                            if (m_a[k][j] == st_addr) m_hit = j;
                    if (m_hit >= 0 && !(m_pop && m_hit == 0)) begin
                        m_d[k][m_hit] = st_data;
                    end else begin
                        m_a[k][m_n[k]] = st_addr;
                        m_d[k][m_n[k]] = st_data;
                        m_n[k]++;
                    end
                end
                if (m_pop) begin
                    for (int j = 0; j < m_n[k] - 1; j++) begin
                        m_a[k][j] = m_a[k][j+1];
                        m_d[k][j] = m_d[k][j+1];
                    end
                    m_n[k]--;
                end
            end
        end
    end

    always @(negedge clock) begin
        for (int k = 0; k < 2; k++) begin
            cmp_ld = e_ld(k);
            chk($sformatf("st_ready[%0d]", k), 32'(rdy_w[k]), 32'(e_ready(k)));
            chk($sformatf("d_we[%0d]", k), 32'(we_w[k]), 32'(e_we(k)));
            chk($sformatf("count[%0d]", k), 32'(cnt_w[k]), 32'(m_n[k]));
            chk($sformatf("empty[%0d]", k), 32'(empty_w[k]), 32'(m_n[k] == 0));
            chk($sformatf("ld_hit[%0d]", k), 32'(hit_w[k]), 32'(cmp_ld[DW]));
            chk($sformatf("ld_data[%0d]", k), 32'(ldd_w[k]), 32'(cmp_ld[DW-1:0]));
            if (m_n[k] > 0) begin
                chk($sformatf("d_addr[%0d]", k), 32'(da_w[k]), 32'(m_a[k][0]));
                chk($sformatf("d_dataout[%0d]", k), 32'(dd_w[k]), 32'(m_d[k][0]));
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        cyc();
        st_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        enable   = 1'b1;
        d_ready  = 1'b1;
        st_valid = 1'b0;
        flush    = 1'b0;
        while (empty_w != 2'b11 && n < 40) begin
            cyc();
            n++;
        end
        chk("drain_bound", 32'(n < 40), 32'd1);
    endtask

    initial begin
        #1 reset = 1'b0;
        repeat (2) cyc();
        chk("rst_count", 32'(cnt_w[1]), 32'd0);
        chk("rst_empty", 32'(empty_w[1]), 32'd1);
        chk("rst_st_ready", 32'(rdy_w[1]), 32'd1);
        chk("rst_d_we", 32'(we_w[1]), 32'd0);
        chk("rst_d_addr", 32'(da_w[1]), 32'd0);
        chk("rst_d_dataout", 32'(dd_w[1]), 32'd0);
        reset = 1'b1;

        // single store into empty buffer
        store(8'h34, 16'hABCD);
        chk("t1_d_we", 32'(we_w[1]), 32'd1);
        chk("t1_d_addr", 32'(da_w[1]), 32'h34);
        chk("t1_d_dataout", 32'(dd_w[1]), 32'hABCD);
        cyc();
        chk("t1_empty", 32'(empty_w[1]), 32'd1);

        // fill to full, fifth store held off until after the first pop
        d_ready = 1'b0;
        for (int i = 0; i < 4; i++) store(AW'(8'h10 + i), DW'(16'h0100 + i));
        chk("t2_count_full", 32'(cnt_w[1]), 32'd4);
        chk("t2_st_ready_full", 32'(rdy_w[1]), 32'd0);
        st_valid = 1'b1; st_addr = 8'h14; st_data = 16'h0114;
        cyc();
        chk("t2_held_count", 32'(cnt_w[1]), 32'd4);
        d_ready = 1'b1;
        chk("t2_first_out", 32'(da_w[1]), 32'h10);
        cyc();
        chk("t2_st_ready_back", 32'(rdy_w[1]), 32'd1);
        chk("t2_second_out", 32'(da_w[1]), 32'h11);
        chk("t2_count_after_pop", 32'(cnt_w[1]), 32'd3);
        cyc();
        st_valid = 1'b0;
        chk("t2_fifth_taken", 32'(cnt_w[1]), 32'd3);
        drain();

        // coalescing vs non-coalescing instance
        d_ready = 1'b0;
        store(8'h20, 16'h1111);
        store(8'h21, 16'h2222);
        store(8'h21, 16'h3333);
        ld_addr = 8'h21;
        #1;
        chk("t3_count_co", 32'(cnt_w[1]), 32'd2);
        chk("t3_count_noco", 32'(cnt_w[0]), 32'd3);
        chk("t3_hit_co", 32'(hit_w[1]), 32'd1);
        chk("t3_data_co", 32'(ldd_w[1]), 32'h3333);
        chk("t3_data_noco", 32'(ldd_w[0]), 32'h3333);
        drain();

        // store to the address of the head being popped allocates a new entry
        d_ready = 1'b0;
        store(8'h40, 16'h0005);
        st_valid = 1'b1; st_addr = 8'h40; st_data = 16'h0006;
        d_ready = 1'b1;
        chk("t4_head_old", 32'(dd_w[1]), 32'h0005);
        cyc();
        st_valid = 1'b0;
        chk("t4_count", 32'(cnt_w[1]), 32'd1);
        chk("t4_new_data", 32'(dd_w[1]), 32'h0006);
        drain();

        // enable low freezes draining
        enable = 1'b0;
        d_ready = 1'b1;
        store(8'h50, 16'h5050);
        store(8'h51, 16'h5151);
        for (int i = 0; i < 5; i++) begin
            chk("t5_we_frozen", 32'(we_w[1]), 32'd0);
            chk("t5_count_hold", 32'(cnt_w[1]), 32'd2);
            cyc();
        end
        enable = 1'b1;
        #1;
        chk("t5_we_resume", 32'(we_w[1]), 32'd1);
        drain();

        // asynchronous reset mid-drain
        d_ready = 1'b0;
        store(8'h60, 16'h6060);
        store(8'h61, 16'h6161);
        store(8'h62, 16'h6262);
        d_ready = 1'b1;
        chk("t6_count_pre", 32'(cnt_w[1]), 32'd3);
        #2 reset = 1'b0;
        #1;
        chk("t6_d_we", 32'(we_w[1]), 32'd0);
        chk("t6_count", 32'(cnt_w[1]), 32'd0);
        for (int a = 0; a < 256; a++) begin
            ld_addr = AW'(a);
            #1;
            chk("t6_ld_hit", 32'(hit_w[1]), 32'd0);
        end
        cyc();
        reset = 1'b1;
        cyc();
        chk("t6_empty_after", 32'(empty_w[1]), 32'd1);

        // randomized traffic on a small address set to exercise coalescing and forwarding
        for (int i = 0; i < 3000; i++) begin
            enable   = ($urandom_range(0, 7) != 0);
            flush    = ($urandom_range(0, 15) == 0);
            d_ready  = 1'($urandom_range(0, 1));
            st_valid = 1'($urandom_range(0, 1));
            st_addr  = AW'(8'h70 + $urandom_range(0, 3));
            st_data  = DW'($urandom);
            ld_addr  = AW'(8'h70 + $urandom_range(0, 4));
            cyc();
        end
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
